// File: rtl/matrix_pkg.sv
// matrix_pkg: shared state encoding and bus widths for the matrix merge block
package matrix_pkg;
    localparam int MAT_ADDR_W  = 12;
    localparam int BANK_ADDR_W = 6;
    localparam int DATA_W      = 16;
    typedef enum logic [1:0] {IDLE, READ, FLUSH} state_t;
endpackage

// File: rtl/matrix_merge_if.sv
// matrix_merge_if: control, bank-read and destination-write signals of matrix_merge (MATRIX_MERGE_BASE_EN adds base_addr_in)
interface matrix_merge_if #(parameter int CNT = 64, parameter int BIT = $clog2(CNT)) ();
    import matrix_pkg::*;
    logic                           start_in;
    logic [BIT:0]                   row_cnt_in;
    logic [BIT:0]                   col_cnt_in;
    logic                           rdy_out;
    logic                           done_out;
    logic [BANK_ADDR_W-1:0]         addrb_out;
    logic [CNT-1:0][DATA_W-1:0]     doutb_in;
    logic                           wea_out;
    logic [MAT_ADDR_W-1:0]          addra_out;
    logic [DATA_W-1:0]              dina_out;
`ifdef MATRIX_MERGE_BASE_EN
    logic [MAT_ADDR_W-1:0]          base_addr_in;
    modport slave (input start_in, row_cnt_in, col_cnt_in, doutb_in, base_addr_in,
                   output rdy_out, done_out, addrb_out, wea_out, addra_out, dina_out);
    modport master (output start_in, row_cnt_in, col_cnt_in, doutb_in, base_addr_in,
                    input rdy_out, done_out, addrb_out, wea_out, addra_out, dina_out);
`else
    modport slave (input start_in, row_cnt_in, col_cnt_in, doutb_in,
                   output rdy_out, done_out, addrb_out, wea_out, addra_out, dina_out);
    modport master (output start_in, row_cnt_in, col_cnt_in, doutb_in,
                    input rdy_out, done_out, addrb_out, wea_out, addra_out, dina_out);
`endif
endinterface

// File: rtl/matrix_addr_gen.sv
// matrix_addr_gen: block/element counters and incremental destination address
module matrix_addr_gen import matrix_pkg::*; #(
    parameter bit IS_ROW = 1'b1,
    parameter int BIT    = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic [BIT:0]          rows,
    input  logic [BIT:0]          cols,
    output logic [BIT-1:0]        elem,
    output logic [BIT-1:0]        blk,
    output logic [MAT_ADDR_W-1:0] addr,
    output logic                  last
);
    logic [BIT-1:0]        elem_q, elem_d, blk_q, blk_d;
    logic [MAT_ADDR_W-1:0] addr_q, addr_d, base_q, base_d, elem_step, blk_step;
    logic [BIT:0]          len, nblk;
    logic                  elem_last, blk_last;
    // Element steps within a block, block steps move the block start; address tracks both without multiplying
    always_comb begin
        len       = IS_ROW ? cols : rows;
        nblk      = IS_ROW ? rows : cols;
        elem_step = IS_ROW ? MAT_ADDR_W'(1) : MAT_ADDR_W'(cols);
        blk_step  = IS_ROW ? MAT_ADDR_W'(cols) : MAT_ADDR_W'(1);
        elem_last = (BIT+1)'(elem_q) + (BIT+1)'(1) == len;
        blk_last  = (BIT+1)'(blk_q) + (BIT+1)'(1) == nblk;
        last      = elem_last && blk_last;
        elem_d    = (!run || elem_last) ? '0 : elem_q + BIT'(1);
        blk_d     = !run ? '0 : elem_last ? blk_q + BIT'(1) : blk_q;
        base_d    = !run ? '0 : elem_last ? base_q + blk_step : base_q;
        addr_d    = !run ? '0 : elem_last ? base_q + blk_step : addr_q + elem_step;
        elem      = elem_q;
        blk       = blk_q;
        addr      = addr_q;
    end
    // Counters are held at zero whenever no read sweep is running
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            elem_q <= '0;
            blk_q  <= '0;
            base_q <= '0;
            addr_q <= '0;
        end else begin
            elem_q <= elem_d;
            blk_q  <= blk_d;
            base_q <= base_d;
            addr_q <= addr_d;
        end
    end
endmodule

// File: rtl/matrix_merge.sv
// matrix_merge: gathers a matrix spread over CNT banks into one destination BRAM (MATRIX_MERGE_BASE_EN adds a base address)
module matrix_merge import matrix_pkg::*; #(
    parameter string STYLE = "ROW",
    parameter int    CNT   = 64,
    parameter int    BIT   = $clog2(CNT)
) (
    input logic           clk,
    input logic           rst_n,
    matrix_merge_if.slave bus
);
    localparam bit           IS_ROW = (STYLE == "ROW");
    localparam logic [BIT:0] CNT_W  = (BIT+1)'(CNT);
    state_t                state_q, state_d;
    logic                  start_q, flush_q, flush_d, done_q, done_d, rdy_q, rdy_d;
    logic [BIT:0]          rows_q, rows_d, cols_q, cols_d, rows_sat, cols_sat;
    logic                  v1_q, v1_d, wea_q, wea_d, go, zero, last;
    logic [BIT-1:0]        bsel_q, bsel_d, elem, blk;
    logic [MAT_ADDR_W-1:0] dst1_q, dst1_d, addra_q, addra_d, addr, base;
    logic [DATA_W-1:0]     dina_q, dina_d;
`ifdef MATRIX_MERGE_BASE_EN
    logic [MAT_ADDR_W-1:0] base_q, base_d;
    assign base_d = go ? bus.base_addr_in : base_q;
    assign base   = base_q;
`else
    assign base = '0;
`endif
    matrix_addr_gen #(.IS_ROW(IS_ROW), .BIT(BIT)) u_gen (
        .clk(clk), .rst_n(rst_n), .run(state_q == READ), .rows(rows_q), .cols(cols_q),
        .elem(elem), .blk(blk), .addr(addr), .last(last)
    );
    // Start detection, FSM next state and the two-stage read/write pipeline
    always_comb begin
        rows_sat = (bus.row_cnt_in > CNT_W) ? CNT_W : bus.row_cnt_in;
        cols_sat = (bus.col_cnt_in > CNT_W) ? CNT_W : bus.col_cnt_in;
        go       = bus.start_in && !start_q && state_q == IDLE;
        zero     = rows_sat == '0 || cols_sat == '0;
        state_d  = (state_q == IDLE) ? ((go && !zero) ? READ : IDLE) :
                   (state_q == READ) ? (last ? FLUSH : READ) : (flush_q ? IDLE : FLUSH);
        flush_d  = state_q == FLUSH && !flush_q;
        done_d   = (go && zero) || (state_q == FLUSH && flush_q);
        rdy_d    = state_d == IDLE;
        rows_d   = go ? rows_sat : rows_q;
        cols_d   = go ? cols_sat : cols_q;
        v1_d     = state_q == READ;
        bsel_d   = blk;
        dst1_d   = addr;
        wea_d    = v1_q;
        addra_d  = v1_q ? dst1_q + base : addra_q;
        dina_d   = v1_q ? bus.doutb_in[bsel_q] : dina_q;
    end
    // All state and outputs registered; reset aborts any merge and blocks a held start
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            start_q <= 1'b1;
            flush_q <= 1'b0;
            done_q  <= 1'b0;
            rdy_q   <= 1'b1;
            rows_q  <= '0;
            cols_q  <= '0;
            v1_q    <= 1'b0;
            bsel_q  <= '0;
            dst1_q  <= '0;
            wea_q   <= 1'b0;
            addra_q <= '0;
            dina_q  <= '0;
`ifdef MATRIX_MERGE_BASE_EN
            base_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            start_q <= bus.start_in;
            flush_q <= flush_d;
            done_q  <= done_d;
            rdy_q   <= rdy_d;
            rows_q  <= rows_d;
            cols_q  <= cols_d;
            v1_q    <= v1_d;
            bsel_q  <= bsel_d;
            dst1_q  <= dst1_d;
            wea_q   <= wea_d;
            addra_q <= addra_d;
            dina_q  <= dina_d;
`ifdef MATRIX_MERGE_BASE_EN
            base_q  <= base_d;
`endif
        end
    end
    assign bus.rdy_out   = rdy_q;
    assign bus.done_out  = done_q;
    assign bus.addrb_out = BANK_ADDR_W'(elem);
    assign bus.wea_out   = wea_q;
    assign bus.addra_out = addra_q;
    assign bus.dina_out  = dina_q;
endmodule

// File: tb/tb_matrix_merge.sv
// tb_matrix_merge: scoreboard bench for ROW and COL instances of matrix_merge
module tb_matrix_merge;
    typedef struct packed { logic [11:0] a; logic [15:0] d; } wr_t;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    wr_t  q0[$];
    wr_t  q1[$];
    int   nw[2] = '{0, 0};
    int   dn[2] = '{0, 0};
    int   done_c[2] = '{-1, -1};
    int   first_c[2] = '{-1, -1};
    int   last_c[2] = '{-1, -1};
    int   last_a[2] = '{-1, -1};
    bit   pw[2] = '{1'b0, 1'b0};

    matrix_merge_if #(.CNT(64)) ir ();
    matrix_merge_if #(.CNT(64)) ic ();
    matrix_merge #(.STYLE("ROW"), .CNT(64)) u_row (.clk(clk), .rst_n(rst_n), .bus(ir));
    matrix_merge #(.STYLE("COL"), .CNT(64)) u_col (.clk(clk), .rst_n(rst_n), .bus(ic));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bank model: bank b, element e holds b*256+e, one-cycle read latency
    always @(posedge clk) begin
        for (int b = 0; b < 64; b++) begin
            ir.doutb_in[b] <= 16'(b * 256) + 16'(ir.addrb_out);
            ic.doutb_in[b] <= 16'(b * 256) + 16'(ic.addrb_out);
        end
    end

    always @(negedge clk) begin
        wr_t e;
        if (ir.wea_out) begin
            if (!pw[0]) first_c[0] = cyc;
            last_c[0] = cyc;
            nw[0]++;
            last_a[0] = int'(ir.addra_out);
            checks++;
            assert (q0.size() > 0) else begin errors++; $error("FAIL row_extra_write addr=%0d expected no write", ir.addra_out); end
            if (q0.size() > 0) begin
                e = q0.pop_front();
                checks++;
                assert ({ir.addra_out, ir.dina_out} === {e.a, e.d})
                else begin errors++; $error("FAIL row_write got a=%0d d=%h expected a=%0d d=%h", ir.addra_out, ir.dina_out, e.a, e.d); end
            end
        end
        pw[0] = ir.wea_out;
        if (ir.done_out) begin dn[0]++; done_c[0] = cyc; end
        if (ic.wea_out) begin
            if (!pw[1]) first_c[1] = cyc;
            last_c[1] = cyc;
            nw[1]++;
            last_a[1] = int'(ic.addra_out);
            checks++;
            assert (q1.size() > 0) else begin errors++; $error("FAIL col_extra_write addr=%0d expected no write", ic.addra_out); end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                checks++;
                assert ({ic.addra_out, ic.dina_out} === {e.a, e.d})
                else begin errors++; $error("FAIL col_write got a=%0d d=%h expected a=%0d d=%h", ic.addra_out, ic.dina_out, e.a, e.d); end
            end
        end
        pw[1] = ic.wea_out;
        if (ic.done_out) begin dn[1]++; done_c[1] = cyc; end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin errors++; $error("FAIL %s got %0d expected %0d", tag, obs, exp); end
    endtask

    task automatic drive(input bit sel, input bit s, input int r, input int c, input int base);
        if (sel) begin
            ic.start_in = s; ic.row_cnt_in = 7'(r); ic.col_cnt_in = 7'(c);
`ifdef MATRIX_MERGE_BASE_EN
            ic.base_addr_in = 12'(base);
`endif
        end else begin
            ir.start_in = s; ir.row_cnt_in = 7'(r); ir.col_cnt_in = 7'(c);
`ifdef MATRIX_MERGE_BASE_EN
            ir.base_addr_in = 12'(base);
`endif
        end
    endtask

    // Expected writes: ROW walks rows then columns, COL walks columns then rows
    task automatic push_exp(input bit sel, input int r, input int c, input int base);
        int rs, cs;
        wr_t w;
        rs = r > 64 ? 64 : r;
        cs = c > 64 ? 64 : c;
        for (int b = 0; b < (sel ? cs : rs); b++)
            for (int e = 0; e < (sel ? rs : cs); e++) begin
                w.a = 12'(base + (sel ? e * cs + b : b * cs + e));
                w.d = 16'(b * 256 + e);
                if (sel) q1.push_back(w); else q0.push_back(w);
            end
    endtask

    task automatic merge(input bit sel, input int r, input int c, input int base, input bit dbl);
        int rs, cs, k, nexp, n0, d0;
        rs = r > 64 ? 64 : r;
        cs = c > 64 ? 64 : c;
        nexp = rs * cs;
        push_exp(sel, r, c, base);
        n0 = nw[sel];
        d0 = dn[sel];
        @(posedge clk); #1;
        drive(sel, 1'b1, r, c, base);
        k = cyc;
        @(posedge clk); #1;
        drive(sel, 1'b0, 0, 0, 0);
        chk("rdy_after_start", sel ? ic.rdy_out : ir.rdy_out, nexp == 0);
        if (dbl) begin
            repeat (3) @(posedge clk);
            #1 drive(sel, 1'b1, 2, 2, 0);
            @(posedge clk);
            #1 drive(sel, 1'b0, 0, 0, 0);
        end
        for (int i = 0; i < 5000 && dn[sel] == d0; i++) @(negedge clk);
        chk("done_cycle", done_c[sel], k + (nexp == 0 ? 1 : nexp + 3));
        chk("write_count", nw[sel] - n0, nexp);
        if (nexp != 0) begin
            chk("first_write_cycle", first_c[sel], k + 3);
            chk("last_write_cycle", last_c[sel], k + nexp + 2);
        end
        chk("queue_empty", sel ? q1.size() : q0.size(), 0);
        @(posedge clk); #1;
        chk("done_single_pulse", dn[sel] - d0, 1);
        chk("rdy_idle", sel ? ic.rdy_out : ir.rdy_out, 1);
    endtask

    initial begin
        int n0, nr;
        rst_n = 1'b0;
        drive(0, 1'b0, 0, 0, 0);
        drive(1, 1'b0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", ir.rdy_out, 1);
        chk("rst_done", ir.done_out, 0);
        chk("rst_wea", ir.wea_out, 0);
        chk("rst_addra", ir.addra_out, 0);
        chk("rst_dina", ir.dina_out, 0);
        chk("rst_addrb", ir.addrb_out, 0);
        chk("rst_col_wea", ic.wea_out, 0);
        rst_n = 1'b1;
        merge(0, 3, 4, 0, 0);
        merge(1, 3, 4, 0, 0);
        merge(0, 0, 4, 0, 0);
        merge(1, 5, 0, 0, 0);
        merge(0, 3, 4, 0, 1);
        merge(1, 2, 100, 0, 0);
        merge(0, 64, 64, 0, 0);
        chk("full_last_addr", last_a[0], 4095);
`ifdef MATRIX_MERGE_BASE_EN
        merge(0, 2, 4, 4090, 0);
        chk("base_wrap_last_addr", last_a[0], 1);
`endif
        push_exp(0, 3, 4, 0);
        n0 = nw[0];
        @(posedge clk); #1;
        drive(0, 1'b1, 3, 4, 0);
        for (int i = 0; i < 100 && nw[0] - n0 < 5; i++) begin @(posedge clk); #1; end
        chk("writes_before_reset", nw[0] - n0, 5);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_wea", ir.wea_out, 0);
        chk("abort_rdy", ir.rdy_out, 1);
        q0.delete();
        nr = nw[0];
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("held_start_no_restart", nw[0], nr);
        chk("held_start_rdy", ir.rdy_out, 1);
        drive(0, 1'b0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/matrix_merge.md
MATRIX_MERGE -- requirements
Module: matrix_merge

Interface
REQ-001 Parameter STYLE, default "ROW", meaning: "ROW" means bank i holds matrix row i; any other value means bank i holds column i.
REQ-002 Parameter CNT, default 64, meaning: number of source banks and maximum dimension.
REQ-003 Parameter BIT, default $clog2(CNT), meaning: counter width.
REQ-004 The block SHALL use one clock and a synchronous active-low reset: clk and rst_n.
REQ-005 clk  in  1  sole clock, all logic on rising edge.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 start_in  in  1  merge request; a rising edge is acted on.
REQ-008 row_cnt_in  in  BIT+1  matrix row count.
REQ-009 col_cnt_in  in  BIT+1  matrix column count.
REQ-010 rdy_out  out  1  high in IDLE.
REQ-011 done_out  out  1  one-cycle pulse when a merge completes.
REQ-012 addrb_out  out  6  read address broadcast to all banks.
REQ-013 doutb_in  in  CNT x 16  bank read data, 1-cycle read latency.
REQ-014 wea_out  out  1  write strobe to destination BRAM.
REQ-015 addra_out  out  12  destination write address.
REQ-016 dina_out  out  16  destination write data.

Function
REQ-017 The FSM SHALL have states IDLE, READ and FLUSH: IDLE->READ on start edge with nonzero dims, READ->FLUSH after the last element address, FLUSH->IDLE after 2 cycles.
REQ-018 Start edge SHALL be start_in high in cycle N with registered start_in low; dims are latched in N.
REQ-019 A start edge outside IDLE SHALL be ignored.
REQ-020 A start edge with row_cnt_in==0 or col_cnt_in==0 SHALL produce no writes, pulse done_out in N+1, and stay IDLE.
REQ-021 Dimensions above CNT SHALL saturate to CNT.
REQ-022 READ SHALL issue one bank address per cycle with no bubbles. The address is elem 0..L-1 for block 0..B-1: ROW gives L=col, B=row; COL gives L=row, B=col.
REQ-023 Bank select SHALL be the block index delayed by one cycle, to align with doutb_in.
REQ-024 Destination address SHALL be block*col+elem for ROW and elem*col+block for COL, computed incrementally without multipliers, 12-bit.
REQ-025 wea_out/addra_out/dina_out SHALL be registered. The first write is in cycle N+3, and exactly row*col consecutive writes follow.
REQ-026 done_out SHALL pulse and rdy_out SHALL rise in the cycle after the last write.
REQ-027 wea_out SHALL be low whenever no valid element is present.

Reset
REQ-028 On rst_n low at a clock edge: state=IDLE, rdy_out=1, done_out=0, wea_out=0, addra_out=0, dina_out=0, addrb_out=0, counters 0, registered start=1 (a held start does not retrigger).
REQ-029 Reset mid-merge SHALL abort the merge; no writes occur from the next cycle on.

Configuration
REQ-030 Macro MATRIX_MERGE_BASE_EN, when defined, SHALL add input base_addr_in[11:0], latched at start. addra_out becomes base+computed address, modulo 4096.
REQ-031 Without MATRIX_MERGE_BASE_EN the port SHALL be absent and the base is 0.

Structure
REQ-032 Package matrix_pkg SHALL hold the state enum and the constants MAT_ADDR_W=12, BANK_ADDR_W=6 and DATA_W=16, shared with the split block.
REQ-033 Sub-module matrix_addr_gen SHALL hold the block/elem counters and the incremental destination address.
REQ-034 The bank mux and the FSM SHALL be in the top level.

Verification
REQ-035 ROW, 3x4, bank r holds r*16+c: start -> first write N+3; addra 0..11 in order; dina = bank r elem c; done at N+15.
REQ-036 COL, 3x4: bank c elem r written in order of increasing c, then r. Addresses are 0,4,8,1,5,9,2,6,10,3,7,11.
REQ-037 64x64 ROW: exactly 4096 writes; last addra=4095 with no wrap; done follows the last write.
REQ-038 row_cnt_in=0 start -> no wea_out, done pulse at N+1, rdy_out stays 1; a second start during a merge is ignored.
REQ-039 rst_n low at write 5 of 12 -> wea_out 0 next cycle, state IDLE; a held start_in does not restart.
REQ-040 MATRIX_MERGE_BASE_EN with base=4090, 2x4 ROW -> addra 4090..4095, 0, 1.
